// File: rtl/comm_pkg.sv
// comm_pkg: shared definitions for the word-to-UART transmitter slice.
//   - tx_state_e          : fetch/send FSM state encoding
//   - DEFAULT_HEADER_BYTE : first byte of every frame unless overridden
//   - UART_FRAME_BITS     : bits per UART character (start + 8 data + stop)
package comm_pkg;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
    localparam int         UART_FRAME_BITS     = 10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        DONE
    } tx_state_e;

endpackage

// File: rtl/word_uart_tx_if.sv
// word_uart_tx_if: pop-style handshake between an upstream word buffer and
// the word transmitter.
//   buf_ready : buffer holds at least one word
//   buf_out   : word presented by the buffer, valid the cycle after rd_enable
//   rd_enable : one-cycle pop request issued by the transmitter
// Modports: master = transmitter side (issues pops), slave = buffer side.
interface word_uart_tx_if #(
    parameter int WIDTH = 32
);

    logic             buf_ready;
    logic [WIDTH-1:0] buf_out;
    logic             rd_enable;

    modport master (
        input  buf_ready,
        input  buf_out,
        output rd_enable
    );

    modport slave (
        output buf_ready,
        output buf_out,
        input  rd_enable
    );

endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for a single byte.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   load     : capture data and start its start bit on the next cycle;
//              accepted even in the done cycle so bytes can run back-to-back
//   data     : byte to send, LSB first
//   tx       : serial line, idle high
//   done     : high during the final cycle of the stop bit
module uart_tx_byte
    import comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int                 BIT_W    = $clog2(UART_FRAME_BITS);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(UART_FRAME_BITS - 1);

    logic                       active;
    logic [CNT_W-1:0]           bit_cnt;
    logic [BIT_W-1:0]           bit_idx;
    logic [UART_FRAME_BITS-1:0] shifter;

    // The whole character (stop, data, start) sits in one shift register,
    // so the line is always just its LSB while active.
    assign tx   = active ? shifter[0] : 1'b1;
    assign done = active && (bit_cnt == CNT_LAST) && (bit_idx == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shifter <= '1;
        end else if (load) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shifter <= {1'b1, data, 1'b0};
        end else if (active) begin
            if (bit_cnt == CNT_LAST) begin
                bit_cnt <= '0;
                shifter <= {1'b1, shifter[UART_FRAME_BITS-1:1]};
                if (bit_idx == BIT_LAST) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/word_uart_tx.sv
// word_uart_tx: pops one word from an upstream buffer and sends it as a UART
// frame: header byte, payload bytes LSB byte first, optional XOR checksum.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   buf_if   : word_uart_tx_if.master (buf_ready, buf_out in; rd_enable out)
//   tx       : UART line, idle high
//   busy     : high from FETCH entry until the end of the last stop bit
// Build option: define WORD_UART_TX_CHECKSUM_EN to append a checksum byte
// equal to the XOR of all payload bytes (header excluded).
module word_uart_tx
    import comm_pkg::*;
#(
    parameter int         VARIABLE_LENGTH_BITS = 32,
    parameter int         CLKS_PER_BIT         = 234,
    parameter logic [7:0] HEADER_BYTE          = DEFAULT_HEADER_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    word_uart_tx_if.master        buf_if,
    output logic                  tx,
    output logic                  busy
);

    localparam int PAYLOAD_BYTES = VARIABLE_LENGTH_BITS / 8;
`ifdef WORD_UART_TX_CHECKSUM_EN
    localparam int CHECKSUM_BYTES = 1;
`else
    localparam int CHECKSUM_BYTES = 0;
`endif
    localparam int             TOTAL_BYTES = 1 + PAYLOAD_BYTES + CHECKSUM_BYTES;
    localparam int             IDX_W       = $clog2(TOTAL_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL_BYTES - 1);

    tx_state_e                       state;
    tx_state_e                       next_state;
    logic [VARIABLE_LENGTH_BITS-1:0] word_reg;
    logic [IDX_W-1:0]                byte_idx;
    logic [IDX_W-1:0]                next_idx;
    logic [7:0]                      next_byte;
    logic                            last_byte;
    logic                            rd_enable;
    logic                            ser_load;
    logic [7:0]                      ser_data;
    logic                            ser_tx;
    logic                            ser_done;

    assign buf_if.rd_enable = rd_enable;
    assign last_byte        = (byte_idx == LAST_IDX);
    assign tx               = (state == SEND) ? ser_tx : 1'b1;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .load (ser_load),
        .data (ser_data),
        .tx   (ser_tx),
        .done (ser_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // byte_idx names the byte currently on the line; the header is index 0
    // and is loaded in WAIT so the first start bit lands on the first SEND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg <= '0;
            byte_idx <= '0;
        end else begin
            if (state == WAIT) begin
                word_reg <= buf_if.buf_out;
                byte_idx <= '0;
            end else if (state == SEND && ser_done && !last_byte) begin
                byte_idx <= next_idx;
            end
        end
    end

`ifdef WORD_UART_TX_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            checksum ^= word_reg[8*i +: 8];
        end
    end
`endif

    // Byte that follows the current one: payload bytes occupy indices
    // 1..PAYLOAD_BYTES, the checksum (when built in) the final index.
    always_comb begin
        next_idx  = byte_idx + 1'b1;
        next_byte = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (next_idx == IDX_W'(i + 1)) begin
                next_byte = word_reg[8*i +: 8];
            end
        end
`ifdef WORD_UART_TX_CHECKSUM_EN
        if (next_idx == LAST_IDX) begin
            next_byte = checksum;
        end
`endif
    end

    // Next byte is loaded in the done cycle of the previous one, which keeps
    // stop bit and following start bit adjacent.
    always_comb begin
        next_state = state;
        rd_enable  = 1'b0;
        busy       = 1'b0;
        ser_load   = 1'b0;
        ser_data   = HEADER_BYTE;
        case (state)
            IDLE: begin
                if (buf_if.buf_ready) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                rd_enable  = 1'b1;
                busy       = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                ser_load   = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                busy = 1'b1;
                if (ser_done) begin
                    if (last_byte) begin
                        next_state = DONE;
                    end else begin
                        ser_load = 1'b1;
                        ser_data = next_byte;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/word_uart_tx.md
WORD_UART_TX -- requirements
Module: word_uart_tx

Interface
REQ-001 Parameter VARIABLE_LENGTH_BITS, default 32: width of one buffered word; SHALL be a multiple of 8.
REQ-002 Parameter CLKS_PER_BIT, default 234: clk cycles per UART bit (27 MHz / 115200 Bd); SHALL be ≥ 2.
REQ-003 Parameter HEADER_BYTE, default 8'hA5: first byte of every frame.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 buf_ready  input  1  1 = upstream word buffer holds ≥ 1 word.
REQ-007 buf_out  input  VARIABLE_LENGTH_BITS  word from buffer; valid the cycle after rd_enable.
REQ-008 rd_enable  output  1  one-cycle pop request to the buffer.
REQ-009 tx  output  1  UART line, idle high.
REQ-010 busy  output  1  1 from FETCH entry until end of last stop bit.

Function
REQ-011 FSM states SHALL be IDLE, FETCH, WAIT, SEND, DONE.
REQ-012 IDLE: if buf_ready=1, go to FETCH next cycle; else stay, with tx=1, rd_enable=0, busy=0.
REQ-013 FETCH: rd_enable=1 for exactly this one cycle; go to WAIT.
REQ-014 WAIT: rd_enable=0; at the end of this cycle, latch buf_out into an internal word register; go to SEND.
REQ-015 SEND: transmit the frame HEADER_BYTE, then VARIABLE_LENGTH_BITS/8 payload bytes LSB byte first, then the checksum byte if enabled (REQ-024).
REQ-016 Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-017 Bytes SHALL be back-to-back, with no idle cycles between one stop bit and the next start bit.
REQ-018 After the last stop bit: DONE for one cycle (tx=1, busy=0), then IDLE.
REQ-019 Frame length: (2+VARIABLE_LENGTH_BITS/8)·10·CLKS_PER_BIT cycles with checksum; without checksum, one byte (10·CLKS_PER_BIT cycles) less.
REQ-020 buf_ready SHALL be sampled only in IDLE; changes during a frame are ignored.
REQ-021 At most one rd_enable pulse per frame; no rd_enable while busy is 1 outside FETCH.
REQ-022 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1. The byte index SHALL be wide enough for the header, payload and checksum count.

Reset
REQ-023 When rst=1 at a clock edge: state=IDLE, tx=1, rd_enable=0, busy=0, counters and word register cleared. A frame in progress is abandoned with no further pop, and resumes only via a new IDLE→FETCH.

Configuration
REQ-024 Macro WORD_UART_TX_CHECKSUM_EN defined: append one byte equal to the XOR of all payload bytes (header excluded).
REQ-025 Macro undefined: no checksum byte and no XOR logic; the frame ends after the last payload byte.

Structure
REQ-026 Shared package comm_pkg SHALL hold the FSM state typedef, the default HEADER_BYTE constant and the UART frame bit count (10).
REQ-027 Sub-module uart_tx_byte SHALL serialize one byte (start/load, 8N1, done pulse).
REQ-028 word_uart_tx SHALL contain the fetch FSM, byte sequencing and checksum.

Verification (CLKS_PER_BIT=4, VARIABLE_LENGTH_BITS=32)
REQ-029 Word 0x12345678, checksum on -> tx bytes A5 78 56 34 12 08, frame 240 cycles, exactly one rd_enable pulse.
REQ-030 Same word, checksum off -> bytes A5 78 56 34 12, frame 200 cycles.
REQ-031 buf_ready held 1 with words 0x00000001 and 0xFFFFFFFF -> two frames, each starting with DONE, IDLE, FETCH, WAIT cycles between them; second payload FF FF FF FF, checksum 00.
REQ-032 buf_ready pulsed mid-frame then low -> no extra rd_enable, return to IDLE.
REQ-033 rst asserted during the 3rd payload byte -> tx=1 at the next edge, busy=0; with buf_ready=0 afterwards, no further rd_enable.
REQ-034 buf_ready=0 after reset for 1000 cycles -> tx=1, busy=0, rd_enable=0 throughout.
